// File: rtl/sdram_arbiter_n.sv
// N-channel SDRAM read arbiter for ROM fetch clients, with HPS download writes
// passing through and taking precedence over new read grants.
module sdram_arbiter_n #(
  parameter int unsigned       NCH        = 4,
  parameter int unsigned       AW         = 26,
  parameter int unsigned       CAW        = 19,
  parameter int unsigned       DW         = 64,
  parameter logic [NCH*AW-1:0] CH_BASE    = '0,
  parameter logic [7:0]        BURST_MASK = 8'b0000_1110,
  parameter logic [7:0]        SWAP_MASK  = 8'b0000_0001,
  parameter bit                RR         = 1'b0
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [NCH-1:0]     ch_req,
  input  logic [NCH*CAW-1:0] ch_addr,
  output logic [DW-1:0]      ch_data,
  output logic [NCH-1:0]     ch_valid,
  output logic [NCH-1:0]     ch_busy,
  output logic [NCH-1:0]     ch_ovf,
  output logic               SDRAM_RD,
  output logic               SDRAM_WR,
  output logic               SDRAM_BURST,
  output logic [AW-1:0]      SDRAM_ADDR,
  input  logic [DW-1:0]      SDRAM_DOUT,
  output logic [15:0]        SDRAM_DIN,
  input  logic               SDRAM_READY,
  output logic [1:0]         SDRAM_BS,
  input  logic               DL_EN,
  input  logic [15:0]        DL_DATA,
  input  logic [AW:0]        DL_ADDR,
  input  logic               DL_WR
);

  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                  state_q, state_d;
  logic [NCH-1:0]          pend_q, pend_d;
  logic [NCH-1:0]          ovf_q, ovf_d;
  logic [NCH-1:0]          valid_q, valid_d;
  logic [NCH-1:0][CAW-1:0] addr_q, addr_d;
  logic [GW-1:0]           gnt_q, gnt_d;
  logic [GW-1:0]           last_q, last_d;
  logic                    rd_q, rd_d;
  logic                    burst_q, burst_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic [DW-1:0]           data_q, data_d;
  logic                    old_ready_q;
  logic                    wr_q, wr_d;
  logic [AW-1:0]           dl_addr_q, dl_addr_d;
  logic [15:0]             din_q, din_d;

  logic [GW-1:0]  pick;
  logic [NCH-1:0] gclr;
  logic           ready_fall;
  logic           unused_dl_addr;

  assign ready_fall     = old_ready_q & ~SDRAM_READY;
  assign unused_dl_addr = DL_ADDR[0];

  // Round-robin: lowest pending index above last wins, otherwise wrap to the lowest overall.
  always_comb begin
    pick = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i] && (!RR || (i <= int'(last_q)))) pick = GW'(i);
    end
    if (RR) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (pend_q[i] && (i > int'(last_q))) pick = GW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    rd_d      = rd_q;
    burst_d   = burst_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    valid_d   = '0;
    gclr      = '0;
    unique case (state_q)
      StIdle: begin
        if (!DL_EN && SDRAM_READY && (|pend_q)) begin
          gnt_d   = pick;
          last_d  = pick;
          gclr    = NCH'(1) << pick;
          rd_d    = 1'b1;
          state_d = StIssue;
          for (int i = 0; i < NCH; i++) begin
            if (pick == GW'(i)) begin
              rd_addr_d = CH_BASE[i*AW +: AW] + AW'(addr_q[i]);
              burst_d   = BURST_MASK[i];
            end
          end
        end
      end
      StIssue: begin
        if (ready_fall) begin
          rd_d    = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (SDRAM_READY) begin
          data_d = SDRAM_DOUT;
          for (int i = 0; i < NCH; i++) begin
            if ((gnt_q == GW'(i)) && SWAP_MASK[i]) begin
              data_d[15:0] = {SDRAM_DOUT[7:0], SDRAM_DOUT[15:8]};
            end
          end
          valid_d = NCH'(1) << gnt_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A request on a channel being granted this cycle stays pending and is not an overflow.
  always_comb begin
    pend_d = (pend_q & ~gclr) | ch_req;
    ovf_d  = ovf_q;
    addr_d = addr_q;
    for (int i = 0; i < NCH; i++) begin
      if (ch_req[i]) begin
        addr_d[i] = ch_addr[i*CAW +: CAW];
        if (pend_q[i] && !gclr[i]) ovf_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_d      = wr_q;
    dl_addr_d = dl_addr_q;
    din_d     = din_q;
    if (DL_WR && DL_EN) begin
      wr_d      = 1'b1;
      dl_addr_d = DL_ADDR[AW:1];
      din_d     = DL_DATA;
    end else if (ready_fall) begin
      wr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      ovf_q       <= '0;
      valid_q     <= '0;
      addr_q      <= '0;
      gnt_q       <= '0;
      last_q      <= GW'(NCH - 1);
      rd_q        <= 1'b0;
      burst_q     <= 1'b0;
      rd_addr_q   <= '0;
      data_q      <= '0;
      old_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      rd_q        <= rd_d;
      burst_q     <= burst_d;
      rd_addr_q   <= rd_addr_d;
      data_q      <= data_d;
      old_ready_q <= SDRAM_READY;
    end
  end

  // The download path survives reset while DL_EN is high so a write in flight is not cut.
  always_ff @(posedge clk_sys) begin
    if (reset && !DL_EN) begin
      wr_q      <= 1'b0;
      dl_addr_q <= '0;
      din_q     <= '0;
    end else begin
      wr_q      <= wr_d;
      dl_addr_q <= dl_addr_d;
      din_q     <= din_d;
    end
  end

  assign ch_data     = data_q;
  assign ch_valid    = valid_q;
  assign ch_ovf      = ovf_q;
  assign ch_busy     = pend_q | ((state_q != StIdle) ? (NCH'(1) << gnt_q) : '0);
  assign SDRAM_RD    = rd_q;
  assign SDRAM_WR    = wr_q;
  assign SDRAM_BURST = burst_q;
  assign SDRAM_ADDR  = DL_EN ? dl_addr_q : rd_addr_q;
  assign SDRAM_DIN   = din_q;
  assign SDRAM_BS    = 2'b11;

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Bench for sdram_arbiter_n: a fixed-priority and a round-robin instance share stimulus,
// each with its own SDRAM controller model and scoreboard queues.
module tb_sdram_arbiter_n;

  localparam int BUSY = 5;
  localparam logic [4*26-1:0] BASES = {26'h3FFFFF0, 26'h0900000, 26'h0100000, 26'h0000000};

  typedef struct packed { logic [3:0] oh; logic [25:0] addr; logic burst; } rd_t;
  typedef struct packed { logic [3:0] oh; logic [63:0] data; } val_t;
  typedef struct packed { logic [25:0] addr; logic [15:0] din; } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ch_req;
  logic [75:0] ch_addr;
  logic        dl_en, dl_wr;
  logic [15:0] dl_data;
  logic [26:0] dl_addr;

  logic [1:0][63:0] data, dout;
  logic [1:0][3:0]  valid, busy, ovf;
  logic [1:0]       rd, wr, burst, ready;
  logic [1:0][25:0] addr;
  logic [1:0][15:0] din;
  logic [1:0][1:0]  bs;

  rd_t  q_rd[2][$];
  val_t q_val[2][$];
  wr_t  q_wr[2][$];
  int   cnt[2], wr_cnt[2], rd_dl[2];
  logic [63:0] nxt[2];
  int   total = 0, bad = 0;

  always #5 clk = ~clk;

  sdram_arbiter_n #(.NCH(4), .AW(26), .CAW(19), .DW(64), .CH_BASE(BASES),
                    .BURST_MASK(8'b1110), .SWAP_MASK(8'b0001), .RR(1'b0)) u_fix (
    .clk_sys(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr),
    .ch_data(data[0]), .ch_valid(valid[0]), .ch_busy(busy[0]), .ch_ovf(ovf[0]),
    .SDRAM_RD(rd[0]), .SDRAM_WR(wr[0]), .SDRAM_BURST(burst[0]), .SDRAM_ADDR(addr[0]),
    .SDRAM_DOUT(dout[0]), .SDRAM_DIN(din[0]), .SDRAM_READY(ready[0]), .SDRAM_BS(bs[0]),
    .DL_EN(dl_en), .DL_DATA(dl_data), .DL_ADDR(dl_addr), .DL_WR(dl_wr));

  sdram_arbiter_n #(.NCH(4), .AW(26), .CAW(19), .DW(64), .CH_BASE(BASES),
                    .BURST_MASK(8'b1110), .SWAP_MASK(8'b0001), .RR(1'b1)) u_rr (
    .clk_sys(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr),
    .ch_data(data[1]), .ch_valid(valid[1]), .ch_busy(busy[1]), .ch_ovf(ovf[1]),
    .SDRAM_RD(rd[1]), .SDRAM_WR(wr[1]), .SDRAM_BURST(burst[1]), .SDRAM_ADDR(addr[1]),
    .SDRAM_DOUT(dout[1]), .SDRAM_DIN(din[1]), .SDRAM_READY(ready[1]), .SDRAM_BS(bs[1]),
    .DL_EN(dl_en), .DL_DATA(dl_data), .DL_ADDR(dl_addr), .DL_WR(dl_wr));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] exp_addr(input int ch, input logic [18:0] a);
    logic [4*26-1:0] b;
    b = BASES;
    return b[ch*26 +: 26] + {7'd0, a};
  endfunction

  task automatic push_rd(input int k, input int ch, input logic [18:0] a);
    rd_t r;
    r.oh    = 4'b0001 << ch;
    r.addr  = exp_addr(ch, a);
    r.burst = (ch != 0);
    q_rd[k].push_back(r);
  endtask

  task automatic req_pulse(input logic [3:0] m, input logic [18:0] a0, input logic [18:0] a1,
                           input logic [18:0] a2, input logic [18:0] a3);
    ch_req  = m;
    ch_addr = {a3, a2, a1, a0};
    @(negedge clk);
    ch_req = 4'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      done = (q_rd[0].size() == 0) && (q_rd[1].size() == 0) && (q_val[0].size() == 0) &&
             (q_val[1].size() == 0) && (ready == 2'b11) && (rd == 2'b00) &&
             (busy[0] == 4'b0) && (busy[1] == 4'b0);
      if (!done) @(negedge clk);
    end
    check_eq(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_ctl_ready(input string tag);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      done = (ready == 2'b11) && (wr == 2'b00) && (q_wr[0].size() == 0) &&
             (q_wr[1].size() == 0);
      if (!done) @(negedge clk);
    end
    check_eq(tag, 64'(done), 64'd1);
  endtask

  // SDRAM controller model: accepts a strobe while ready, stays busy BUSY cycles.
  always @(negedge clk) begin : ctl_model
    val_t v;
    rd_t r;
    wr_t w;
    logic [63:0] d;
    for (int k = 0; k < 2; k++) begin
      if (valid[k] != 4'b0) begin
        check_eq("valid_expected", 64'(q_val[k].size() != 0), 64'd1);
        if (q_val[k].size() != 0) begin
          v = q_val[k].pop_front();
          check_eq("valid_onehot", 64'(valid[k]), 64'(v.oh));
          check_eq("valid_data", data[k], v.data);
        end
      end
      if (ready[k]) begin
        if (rd[k]) begin
          ready[k] = 1'b0;
          cnt[k]   = BUSY;
          if (dl_en) rd_dl[k]++;
          check_eq("rd_expected", 64'(q_rd[k].size() != 0), 64'd1);
          if (q_rd[k].size() != 0) begin
            r = q_rd[k].pop_front();
            check_eq("rd_addr", 64'(addr[k]), 64'(r.addr));
            check_eq("rd_burst", 64'(burst[k]), 64'(r.burst));
            d = {$urandom(), 16'($urandom()), 16'hA1B2};
            nxt[k] = d;
            v.oh   = r.oh;
            v.data = (r.oh == 4'b0001) ? {d[63:16], d[7:0], d[15:8]} : d;
            q_val[k].push_back(v);
          end
        end else if (wr[k]) begin
          ready[k] = 1'b0;
          cnt[k]   = BUSY;
          wr_cnt[k]++;
          check_eq("wr_expected", 64'(q_wr[k].size() != 0), 64'd1);
          if (q_wr[k].size() != 0) begin
            w = q_wr[k].pop_front();
            check_eq("wr_addr", 64'(addr[k]), 64'(w.addr));
            check_eq("wr_din", 64'(din[k]), 64'(w.din));
          end
        end
      end else begin
        cnt[k]--;
        if (cnt[k] <= 0) begin
          ready[k] = 1'b1;
          dout[k]  = nxt[k];
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wr_t w;
    reset   = 1'b1;
    ch_req  = '0;
    ch_addr = '0;
    dl_en   = 1'b0;
    dl_wr   = 1'b0;
    dl_data = '0;
    dl_addr = '0;
    ready   = 2'b11;
    dout    = '0;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; wr_cnt[k] = 0; rd_dl[k] = 0; nxt[k] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_valid", 64'({valid[1], valid[0]}), 64'd0);
    check_eq("rst_busy", 64'({busy[1], busy[0]}), 64'd0);
    check_eq("rst_ovf", 64'({ovf[1], ovf[0]}), 64'd0);
    check_eq("rst_rd_wr", 64'({rd, wr, burst}), 64'd0);
    check_eq("rst_data", data[0] | data[1], 64'd0);
    check_eq("bs", 64'({bs[1], bs[0]}), 64'hF);

    // Channel 2 with a large base.
    push_rd(0, 2, 19'h12345);
    push_rd(1, 2, 19'h12345);
    req_pulse(4'b0100, 19'h0, 19'h0, 19'h12345, 19'h0);
    check_eq("t1_busy", 64'({busy[1], busy[0]}), 64'h44);
    wait_idle("t1_done");

    // Set RR last=1, then all four at once.
    push_rd(0, 1, 19'h5);
    push_rd(1, 1, 19'h5);
    req_pulse(4'b0010, 19'h0, 19'h5, 19'h0, 19'h0);
    wait_idle("t2a_done");
    for (int i = 0; i < 4; i++) push_rd(0, i, 19'(32'h100 + i));
    for (int i = 0; i < 4; i++) push_rd(1, (i + 2) % 4, 19'(32'h100 + (i + 2) % 4));
    req_pulse(4'b1111, 19'h100, 19'h101, 19'h102, 19'h103);
    wait_idle("t2b_done");
    check_eq("t2_no_ovf", 64'({ovf[1], ovf[0]}), 64'd0);

    // Swapped, non-burst channel 0.
    push_rd(0, 0, 19'h7);
    push_rd(1, 0, 19'h7);
    req_pulse(4'b0001, 19'h7, 19'h0, 19'h0, 19'h0);
    wait_idle("t3_done");

    // Channel 1 overwritten before service.
    for (int k = 0; k < 2; k++) begin
      push_rd(k, 0, 19'h40);
      push_rd(k, 1, 19'h20);
    end
    req_pulse(4'b0001, 19'h40, 19'h0, 19'h0, 19'h0);
    req_pulse(4'b0010, 19'h0, 19'h10, 19'h0, 19'h0);
    req_pulse(4'b0010, 19'h0, 19'h20, 19'h0, 19'h0);
    wait_idle("t4_done");
    check_eq("t4_ovf", 64'({ovf[1], ovf[0]}), 64'h22);

    // Download writes block a pending channel 3 read.
    dl_en = 1'b1;
    push_rd(0, 3, 19'h9);
    push_rd(1, 3, 19'h9);
    req_pulse(4'b1000, 19'h0, 19'h0, 19'h0, 19'h9);
    for (int j = 0; j < 3; j++) begin
      wait_ctl_ready("t5_wr_ready");
      dl_addr = 27'h400 + 27'(2 * j);
      dl_data = 16'hC000 + 16'(j);
      w.addr  = 26'h200 + 26'(j);
      w.din   = dl_data;
      q_wr[0].push_back(w);
      q_wr[1].push_back(w);
      dl_wr = 1'b1;
      @(negedge clk);
      dl_wr = 1'b0;
    end
    wait_ctl_ready("t5_wr_drain");
    check_eq("t5_wr_count", 64'({wr_cnt[1][7:0], wr_cnt[0][7:0]}), 64'h0303);
    check_eq("t5_no_rd", 64'({rd_dl[1][7:0], rd_dl[0][7:0]}), 64'd0);
    check_eq("t5_busy", 64'({busy[1], busy[0]}), 64'h88);
    check_eq("t5_dl_addr", 64'(addr[0]), 64'h202);
    dl_en = 1'b0;
    @(negedge clk);
    check_eq("t5_rd_after_dl", 64'(rd), 64'h3);
    wait_idle("t5_done");

    // Reset while waiting for read data.
    push_rd(0, 3, 19'h1);
    push_rd(1, 3, 19'h1);
    req_pulse(4'b1000, 19'h0, 19'h0, 19'h0, 19'h1);
    for (int n = 0; n < 50 && (q_rd[0].size() != 0 || q_rd[1].size() != 0); n++) begin
      @(negedge clk);
    end
    check_eq("t6_accepted", 64'(q_rd[0].size() + q_rd[1].size()), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("t6_valid", 64'({valid[1], valid[0]}), 64'd0);
    check_eq("t6_busy_ovf", 64'({busy[1], busy[0], ovf[1], ovf[0]}), 64'd0);
    check_eq("t6_strobes", 64'({rd, wr, burst}), 64'd0);
    check_eq("t6_data", data[0] | data[1], 64'd0);
    check_eq("t6_addr_din", 64'({addr[1], addr[0]}) | 64'({din[1], din[0]}), 64'd0);
    q_val[0].delete();
    q_val[1].delete();
    wait_ctl_ready("t6_ctl_ready");
    push_rd(0, 2, 19'h77);
    push_rd(1, 2, 19'h77);
    req_pulse(4'b0100, 19'h0, 19'h0, 19'h77, 19'h0);
    wait_idle("t6_done");

    check_eq("drained", 64'(q_rd[0].size() + q_rd[1].size() + q_val[0].size() +
                            q_val[1].size() + q_wr[0].size() + q_wr[1].size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter_n.md
Name: sdram_arbiter_n

Overview:
Parametrised N-channel read arbiter between the game's ROM fetch clients (CPU code, tiles, sprites, sound samples) and the SDRAM controller. Each channel posts a pulse request with a channel-relative word address. The block latches the request, rebases the address, and arbitrates by fixed or round-robin priority. It returns data on a shared bus with a per-channel valid strobe. HPS download writes pass through and take precedence over all reads.

Parameters:
NCH, 4, number of read channels (1..8)
AW, 26, SDRAM word address width (SDRAM_ADDR[AW:1])
CAW, 19, channel-relative word address width
DW, 64, SDRAM read data width
CH_BASE, {NCH{AW'd0}}, packed NCH*AW per-channel word base; channel i base = CH_BASE[i*AW +: AW]
BURST_MASK, 4'b1110, bit i=1 -> channel i reads with SDRAM_BURST=1
SWAP_MASK, 4'b0001, bit i=1 -> channel i data bits [15:0] byte-swapped
RR, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous active-high reset
ch_req  in  NCH  per-channel one-cycle request pulse
ch_addr  in  NCH*CAW  packed channel word addresses, sampled when ch_req[i]=1
ch_data  out  DW  shared read data, valid while ch_valid has a bit set
ch_valid  out  NCH  one-cycle pulse; bit i = ch_data belongs to channel i
ch_busy  out  NCH  bit i = channel i pending or in service
ch_ovf  out  NCH  sticky; bit i = a request overwrote an unserved pending request
SDRAM_RD  out  1  read strobe
SDRAM_WR  out  1  write strobe (download only)
SDRAM_BURST  out  1  burst qualifier for current read
SDRAM_ADDR  out  AW  word address [AW:1]
SDRAM_DOUT  in  DW  controller read data
SDRAM_DIN  out  16  write data
SDRAM_READY  in  1  controller idle
SDRAM_BS  out  2  byte select, constant 2'b11
DL_EN  in  1  HPS download active
DL_DATA  in  16  download word
DL_ADDR  in  AW+1  download byte address
DL_WR  in  1  download write pulse

Behaviour:
- Clock clk_sys. Reset synchronous, active-high. Reset clears pending, busy, ch_ovf, ch_valid, the RR pointer (last grant = NCH-1), SDRAM_RD, SDRAM_BURST and ch_data (0). FSM -> IDLE. SDRAM_WR clears on reset only if DL_EN=0, so an in-flight download write is not cut.
- Request latch: ch_req[i] sets pend[i] and stores ch_addr[i] in every state, including reset release +1. If pend[i] is already set, the address is overwritten (latest wins) and ch_ovf[i] is set. A request on the channel currently in service becomes a new pending request; it is not an overflow.
- Address: CH_BASE[i] + zero-extended addr, modulo 2^AW (wraps silently).
- FSM states:
  - IDLE: if DL_EN=0, SDRAM_READY=1 and any pend bit is set, grant one channel. Register SDRAM_ADDR, SDRAM_BURST=BURST_MASK[g], SDRAM_RD=1, clear pend[g]. Go to ISSUE next cycle.
  - ISSUE: hold SDRAM_RD until a READY 1->0 edge (registered old_ready). Then drop SDRAM_RD and go to WAIT.
  - WAIT: when SDRAM_READY=1, capture SDRAM_DOUT into ch_data with SWAP_MASK applied ({D[7:0],D[15:8]} in the low 16 bits, upper bits unchanged). Pulse ch_valid[g] for one cycle. Go to IDLE.
- Timing: grant-to-valid latency = controller busy time + 2 cycles. Back-to-back grants are allowed the cycle after valid.
- Grant: RR=0 picks the lowest pending index. RR=1 searches from last+1 upward with wrap, and updates last on grant.
- ch_busy[i] = pend[i] | (state!=IDLE & g==i).
- Download:
  - DL_EN=1 blocks new grants. An in-service read completes normally. Pending requests are kept.
  - DL_WR&DL_EN registers SDRAM_ADDR=DL_ADDR[AW:1], SDRAM_DIN=DL_DATA, SDRAM_WR=1. SDRAM_WR drops on the READY 1->0 edge.
  - SDRAM_ADDR muxes to the download register while DL_EN=1.
- Simultaneous events: a ch_req and a grant of the same channel in the same cycle -> the new request stays pending. Reset mid-read drops the read with no valid pulse.

Test Plan:
- NCH=4, RR=0, CH_BASE[2]=0x0900000. ch_req[2] with addr 0x12345, controller busy 5 cycles -> SDRAM_ADDR=0x0912345, BURST=1. ch_valid=4'b0100 exactly once, with ch_data=SDRAM_DOUT.
- Same-cycle ch_req=4'b1111, RR=0 -> grant order 0,1,2,3. With RR=1 and last=1 -> order 2,3,0,1.
- Channel 0 with SWAP_MASK bit0, SDRAM_DOUT low 16 = 0xA1B2 -> ch_data[15:0]=0xB2A1, ch_valid=4'b0001, BURST=0.
- Two ch_req[1] pulses before service (addr 0x10 then 0x20) -> a single read at base+0x20, ch_ovf[1]=1 until reset.
- DL_EN=1 with 3 DL_WR pulses while ch_req[3] is pending -> 3 SDRAM_WR transactions and no SDRAM_RD. The channel 3 read issues the first IDLE cycle after DL_EN=0.
- Reset asserted in WAIT -> no ch_valid, all outputs 0. The next request is serviced normally.
